// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state, opsel codes and the initial carry-in rule
// for the slice sequencer and its datapath.
package alu_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b110;

    // Operations built on a+~b+1 style arithmetic need a carry into slice 0.
    function automatic logic cin_required(input logic [2:0] opsel, input logic mode);
        return !mode && (opsel == OP_SUB || opsel == OP_INC || opsel == OP_NEG);
    endfunction

endpackage

// File: rtl/alu_seq_cin_sel.sv
// alu_seq_cin_sel: combinational initial carry-in select, shareable with the datapath.
module alu_seq_cin_sel
    import alu_seq_pkg::*;
(
    input  logic [2:0] opsel,
    input  logic       mode,
    output logic       cin
);

    assign cin = cin_required(opsel, mode);

endmodule

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs one WIDTH-bit ALU op through a SLICE-wide datapath,
// LSB slice first, chaining carry between slices.
module alu_slice_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             slice_en,
    output logic [2:0]       slice_opsel,
    output logic             slice_mode,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    input  logic [SLICE-1:0] slice_result,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       opsel_q, opsel_d;
    logic             mode_q, mode_d;
    logic             init_cin;

    alu_seq_cin_sel u_cin_sel (
        .opsel (opsel),
        .mode  (mode),
        .cin   (init_cin)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        opsel_d  = opsel_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d      = a;
                b_d      = b;
                opsel_d  = opsel;
                mode_d   = mode;
                idx_d    = '0;
                carry_d  = init_cin;
                cout_d   = 1'b0;
                result_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                result_d[idx_q*SLICE +: SLICE] = slice_result;
                // Final slice keeps idx and carry so slice_* hold steady outside RUN.
                if (idx_q == LAST) begin
                    cout_d  = !mode_q && slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    carry_d = !mode_q && slice_cout;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opsel_q  <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opsel_q  <= opsel_d;
            mode_q   <= mode_d;
        end
    end

    assign in_ready    = state_q == IDLE;
    assign slice_en    = state_q == RUN;
    assign out_valid   = state_q == DONE;
    assign busy        = state_q != IDLE;
    assign slice_opsel = opsel_q;
    assign slice_mode  = mode_q;
    assign slice_a     = a_q[idx_q*SLICE +: SLICE];
    assign slice_b     = b_q[idx_q*SLICE +: SLICE];
    assign slice_cin   = carry_q;
    assign result      = result_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: directed vectors with a queue scoreboard popped by an
// output monitor; a small slice ALU model closes the datapath loop.
module tb_alu_slice_sequencer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opsel;
    logic         mode;
    logic [127:0] a;
    logic [127:0] b;
    logic         slice_en;
    logic [2:0]   slice_opsel;
    logic         slice_mode;
    logic [31:0]  slice_a;
    logic [31:0]  slice_b;
    logic         slice_cin;
    logic [31:0]  slice_result;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         cout;
    logic         busy;

    typedef struct {
        logic [127:0] r;
        logic         c;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] B2 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

    alu_slice_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opsel        (opsel),
        .mode         (mode),
        .a            (a),
        .b            (b),
        .slice_en     (slice_en),
        .slice_opsel  (slice_opsel),
        .slice_mode   (slice_mode),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_result (slice_result),
        .slice_cout   (slice_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .cout         (cout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice datapath model: add, subtract (a+~b+cin) and logic AND.
    always_comb begin
        logic [32:0] s;
        s = '0;
        if (slice_mode)
            s = {1'b0, slice_a & slice_b};
        else if (slice_opsel == 3'b000)
            s = {1'b0, slice_a} + {1'b0, slice_b} + {32'd0, slice_cin};
        else if (slice_opsel == 3'b011)
            s = {1'b0, slice_a} + {1'b0, ~slice_b} + {32'd0, slice_cin};
        slice_result = s[31:0];
        slice_cout   = s[32];
    end

    function automatic void chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected got=%h want=none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.r);
                chk("sb_cout", {127'd0, cout}, {127'd0, e.c});
            end
        end
    end

    task automatic push(input logic [127:0] r, input logic c);
        exp_t e;
        e.r = r;
        e.c = c;
        sb.push_back(e);
    endtask

    // Offers a command and returns just after the accepting edge.
    task automatic start(input logic [127:0] aa, input logic [127:0] bb,
                         input logic [2:0] op, input logic md, input logic hold);
        @(posedge clk);
        #1;
        a = aa;
        b = bb;
        opsel = op;
        mode = md;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
        chk("accept_wait", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Follows the four RUN cycles and the first DONE cycle.
    task automatic slices(input logic [3:0] cins);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slice_en", {127'd0, slice_en}, 128'd1);
            chk("slice_cin", {127'd0, slice_cin}, {127'd0, cins[i]});
            chk("run_out_valid", {127'd0, out_valid}, 128'd0);
        end
        @(negedge clk);
        chk("done_out_valid", {127'd0, out_valid}, 128'd1);
        chk("done_slice_en", {127'd0, slice_en}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        opsel = '0;
        mode = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_slice_en", {127'd0, slice_en}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_result", result, 128'd0);
        chk("rst_cout", {127'd0, cout}, 128'd0);

        // Carry ripples through three slices.
        push(128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0);
        start(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 3'b000, 1'b0, 1'b0);
        slices(4'b1110);

        push(ONES, 1'b0);
        start(128'd0, 128'd1, 3'b011, 1'b0, 1'b0);
        slices(4'b0001);

        push(128'd2, 1'b1);
        start(128'd5, 128'd3, 3'b011, 1'b0, 1'b0);
        slices(4'b1111);

        push(B2, 1'b0);
        start(ONES, B2, 3'b000, 1'b1, 1'b0);
        slices(4'b0000);

        // Backpressure in DONE with a new command already offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(128'd12, 1'b0);
        start(128'd5, 128'd7, 3'b000, 1'b0, 1'b0);
        slices(4'b0000);
        @(posedge clk);
        #1;
        push(128'd101, 1'b0);
        a = 128'd100;
        b = 128'd1;
        opsel = 3'b000;
        mode = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_result", result, 128'd12);
            chk("bp_cout", {127'd0, cout}, 128'd0);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", {127'd0, in_ready}, 128'd1);
        chk("bp_idle_out_valid", {127'd0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        slices(4'b0000);

        // Reset while the third slice is being issued.
        start(128'd1, 128'd2, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        chk("abort_result", result, 128'd0);
        chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_slice_en", {127'd0, slice_en}, 128'd0);
        push(128'd8, 1'b0);
        start(128'd5, 128'd3, 3'b000, 1'b0, 1'b0);
        slices(4'b0000);

        // Back-to-back with in_valid held across both commands.
        push(128'd2, 1'b1);
        push(B2, 1'b0);
        start(128'd5, 128'd3, 3'b011, 1'b0, 1'b1);
        a = ONES;
        b = B2;
        opsel = 3'b000;
        mode = 1'b1;
        slices(4'b1111);
        @(negedge clk);
        chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        slices(4'b0000);

        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Multi-cycle controller that runs one 128-bit ALU operation through a narrow SLICE-wide ALU datapath, one slice per cycle, LSB slice first.
- Carry chains between slices; initial carry-in comes from the opsel/mode carry rule.
- Sits between the operand/command source (valid/ready) and the slice datapath; returns the assembled result and carry-out (valid/ready).

Parameters:
- WIDTH, 128, full operand/result width.
- SLICE, 32, datapath slice width; WIDTH % SLICE == 0 required.
- NSLICE, WIDTH/SLICE (derived, localparam), number of slice cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  command/operands offered.
- in_ready  out  1  sequencer can accept (IDLE only).
- opsel  in  3  ALU operation select.
- mode  in  1  0 = arithmetic (carry-chained), 1 = logic.
- a, b  in  WIDTH  operands.
- slice_en  out  1  high while a slice is issued (RUN).
- slice_opsel  out  3  latched opsel.
- slice_mode  out  1  latched mode.
- slice_a, slice_b  out  SLICE  current slice of latched a/b.
- slice_cin  out  1  carry-in for current slice.
- slice_result  in  SLICE  combinational result from datapath, same cycle.
- slice_cout  in  1  combinational carry-out from datapath, same cycle.
- out_valid  out  1  result available (DONE).
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  assembled result.
- cout  out  1  carry-out of the final slice (0 if mode=1).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE, idx=0, carry=0, result=0, cout=0, out_valid=0, slice_en=0, in_ready=1 after reset. Reset mid-RUN/DONE aborts; partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, with in_ready=1:
  - On in_valid, latch a, b, opsel, mode; idx<=0; carry<=init_cin; clear result; go to RUN.
  - init_cin = 1 iff mode=0 and opsel in {3'b011, 3'b100, 3'b110}; otherwise 0.
- RUN, with slice_en=1 and in_ready=0:
  - slice_a/b = latched a/b[idx*SLICE +: SLICE]; slice_cin=carry.
  - Each cycle, result[idx*SLICE +: SLICE] <= slice_result.
  - carry <= (mode==0) ? slice_cout : 0.
  - idx <= idx+1.
  - When idx==NSLICE-1, set cout <= (mode==0) ? slice_cout : 0 and go to DONE.
- DONE, with out_valid=1:
  - result and cout are held stable.
  - On out_ready, go to IDLE (out_valid=0 the next cycle).
  - in_valid is ignored in DONE; a new command is accepted only in IDLE (no same-cycle turnaround).
- Latency:
  - Accept edge T0, slices issued T0+1..T0+NSLICE, out_valid from T0+NSLICE+1.
  - Throughput is one op per NSLICE+2 cycles.
- mode=1: slice_cin=0 for every slice; the datapath carry is ignored.
- Slice outputs are registered/latched values only: no combinational path from in_* to slice_*.
- Outside RUN, slice_* data outputs hold their last values and slice_en=0.
- idx width is clog2(NSLICE), minimum 1; no wrap past NSLICE-1.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - opsel code constants (OP_*);
  - function cin_required(opsel, mode) implementing the init_cin rule.
- Optional sub-module alu_seq_cin_sel: combinational wrapper of cin_required, so the datapath can share it.
- Bench slice model: mode0 opsel 000 computes a+b+cin; opsel 011 computes a+~b+cin; mode1 opsel 000 computes a&b.

Test Plan:
- Add with carry ripple: a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, opsel=000, mode=0 -> result=128'h0000_0001_0000_0000_0000_0000_0000_0000, cout=0, slice_cin sequence 0,1,1,1, out_valid exactly 5 cycles after accept.
- Subtract: a=0, b=1, opsel=011, mode=0 -> slice_cin=1 on slice 0, result=all-ones, cout=0; a=5, b=3 -> result=2, cout=1.
- Logic: a=all-ones, b=128'h1234...(any), opsel=000, mode=1 -> result=b, slice_cin=0 on all 4 slices, cout=0.
- Backpressure: out_ready=0 for 3 cycles in DONE, in_valid=1 -> out_valid/result/cout stable, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle, then accept.
- Reset mid-op: rst_n=0 during RUN at idx=2 -> next cycle IDLE, result=0, out_valid=0, slice_en=0, in_ready=1; next op completes correctly.
- Back-to-back: in_valid held high across two commands -> second accepted on first IDLE cycle after DONE handshake; results are in order and correct.
